// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial transmitter.
package serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // A length field of 0 encodes a full-width word.
  function automatic int unsigned len_decode(
    input int unsigned mod,
    input int unsigned data_w
  );
    return (mod == 0) ? data_w : mod;
  endfunction

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter, MSB first by default.
// Define SERIALIZER_LSB_FIRST_EN to send the bottom bits LSB first.
module serializer
  import serializer_pkg::*;
#(
  parameter  int DATA_W = 16,
  localparam int MOD_W  = $clog2(DATA_W),
  localparam int CNT_W  = MOD_W + 1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] sh_q;
  logic              ser_q;
  logic              val_q;
  logic              busy_q;

  logic [DATA_W-1:0] word_d;
  logic [DATA_W-1:0] sh_d;
  logic              bit_d;
  logic [CNT_W-1:0]  len_d;

  // The head bit is taken from the input on accept, else from the shifter.
  always_comb begin
    word_d = (state_q == IDLE) ? data_i : sh_q;
    len_d  = CNT_W'(len_decode(int'(data_mod_i), DATA_W));
`ifdef SERIALIZER_LSB_FIRST_EN
    bit_d  = word_d[0];
    sh_d   = word_d >> 1;
`else
    bit_d  = word_d[DATA_W-1];
    sh_d   = word_d << 1;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
      val_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (data_val_i) begin
            state_q <= SEND;
            cnt_q   <= len_d;
            sh_q    <= sh_d;
            ser_q   <= bit_d;
            val_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SEND: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ser_q   <= 1'b0;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q - CNT_W'(1);
            sh_q    <= sh_d;
            ser_q   <= bit_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ser_data_o     = ser_q;
  assign ser_data_val_o = val_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: queue-based bit model plus a
// receive-side word assembler for directed and random words.
module tb_serializer;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          srst;
  logic [DW-1:0] din;
  logic [3:0]    dmod;
  logic          dval;
  logic          ser_o;
  logic          ser_val_o;
  logic          busy;

  int total = 0;
  int bad   = 0;

  bit            mq[$];
  logic [DW-1:0] rx_word;
  int            rx_cnt;

  serializer #(.DATA_W(DW)) dut (
    .clk_i          (clk),
    .srst_i         (srst),
    .data_i         (din),
    .data_mod_i     (dmod),
    .data_val_i     (dval),
    .ser_data_o     (ser_o),
    .ser_data_val_o (ser_val_o),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word the link should deliver, bits packed first-received at the top.
  function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] d,
                                             input int len);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < len; k++) begin
`ifdef SERIALIZER_LSB_FIRST_EN
      r = {r[DW-2:0], d[k]};
`else
      r = {r[DW-2:0], d[DW-1-k]};
`endif
    end
    return r;
  endfunction

  function automatic int mlen(input logic [3:0] m);
    return (m == 0) ? DW : int'(m);
  endfunction

  task automatic clr_rx();
    rx_word = '0;
    rx_cnt  = 0;
  endtask

  // One clock: drive, advance model, check all outputs, collect bits.
  task automatic step(input logic r, input logic v,
                      input logic [DW-1:0] d, input logic [3:0] m);
    srst = r; dval = v; din = d; dmod = m;
    @(posedge clk);
    if (r) mq.delete();
    else if (mq.size() > 0) void'(mq.pop_front());
    else if (v) begin
      for (int k = 0; k < mlen(m); k++) begin
`ifdef SERIALIZER_LSB_FIRST_EN
        mq.push_back(d[k]);
`else
        mq.push_back(d[DW-1-k]);
`endif
      end
    end
    #1;
    chk("val",  32'(ser_val_o), 32'(mq.size() > 0));
    chk("busy", 32'(busy),      32'(mq.size() > 0));
    chk("data", 32'(ser_o),     32'((mq.size() > 0) ? mq[0] : 1'b0));
    if (ser_val_o === 1'b1) begin
      rx_word = {rx_word[DW-2:0], ser_o};
      rx_cnt++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [3:0]    m;
    srst = 1'b1; dval = 1'b0; din = '0; dmod = '0;
    clr_rx();
    step(1'b1, 1'b0, '0, '0);
    chk("rst_val",  32'(ser_val_o), 32'd0);
    chk("rst_busy", 32'(busy),      32'd0);
    chk("rst_data", 32'(ser_o),     32'd0);
    idle(2);

    clr_rx();
    step(1'b0, 1'b1, 16'hA5C3, 4'd0);
    idle(16);
    chk("a5c3_cnt",  32'(rx_cnt),  32'd16);
    chk("a5c3_word", 32'(rx_word), 32'(ref_word(16'hA5C3, 16)));
    chk("a5c3_end",  32'(busy),    32'd0);

    clr_rx();
    step(1'b0, 1'b1, 16'hF000, 4'd3);
    idle(3);
    chk("f000_cnt",  32'(rx_cnt),       32'd3);
    chk("f000_word", 32'(rx_word[2:0]), 32'(ref_word(16'hF000, 3)));
    chk("f000_val",  32'(ser_val_o),    32'd0);

    clr_rx();
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 16'h0001, 4'd0);
    chk("hold_w1",  32'(rx_word), 32'(ref_word(16'h0001, 16)));
    chk("hold_gap", 32'(busy),    32'd0);
    clr_rx();
    step(1'b0, 1'b1, 16'h8000, 4'd0);
    chk("hold_acc", 32'(busy), 32'd1);
    idle(16);
    chk("hold_w2", 32'(rx_word), 32'(ref_word(16'h8000, 16)));

    clr_rx();
    step(1'b0, 1'b1, 16'h0000, 4'd0);
    idle(3);
    step(1'b0, 1'b1, 16'hFFFF, 4'd0);
    idle(16);
    chk("ign_cnt",  32'(rx_cnt),  32'd16);
    chk("ign_word", 32'(rx_word), 32'd0);

    step(1'b0, 1'b1, 16'hFFFF, 4'd0);
    idle(6);
    step(1'b1, 1'b0, '0, '0);
    chk("mid_val",  32'(ser_val_o), 32'd0);
    chk("mid_busy", 32'(busy),      32'd0);
    chk("mid_data", 32'(ser_o),     32'd0);
    step(1'b1, 1'b1, 16'h1234, 4'd0);
    chk("rst_wins", 32'(busy), 32'd0);
    clr_rx();
    step(1'b0, 1'b1, 16'h9ABC, 4'd0);
    idle(16);
    chk("post_rst", 32'(rx_word), 32'(ref_word(16'h9ABC, 16)));

    for (int n = 0; n < 1000; n++) begin
      w = DW'($urandom);
      clr_rx();
      step(1'b0, 1'b1, w, 4'd0);
      idle(16);
      chk("loop_cnt",  32'(rx_cnt),  32'd16);
      chk("loop_word", 32'(rx_word), 32'(ref_word(w, 16)));
    end

    for (int n = 0; n < 200; n++) begin
      w = DW'($urandom);
      m = 4'($urandom_range(0, 15));
      clr_rx();
      step(1'b0, 1'b1, w, m);
      for (int i = 0; i < mlen(m); i++)
        step(1'b0, 1'($urandom), DW'($urandom), 4'($urandom));
      chk("rnd_cnt",  32'(rx_cnt),  32'(mlen(m)));
      chk("rnd_word", 32'(rx_word), 32'(ref_word(w, mlen(m))));
      idle(int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
